// File: rtl/pet_stats_engine_if.sv
// Command channel of the pet stats engine: a valid/ready request carrying a
// target stat index and an amount, plus the invalid-id error pulse.
interface pet_stats_engine_if #(
  parameter int STAT_W = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_id;
  logic [STAT_W-1:0] cmd_amount;
  logic              cmd_err;

  modport master (
    output cmd_valid,
    output cmd_id,
    output cmd_amount,
    input  cmd_ready,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_id,
    input  cmd_amount,
    output cmd_ready,
    output cmd_err
  );
endinterface

// File: rtl/pet_stats_engine.sv
// Virtual-pet stat engine: stats decay on a prescaled tick, commands add to them
// with saturation, and an AWAKE/SLEEP/DEAD life-cycle FSM gates both.
module pet_stats_engine #(
  parameter int NUM_STATS  = 5,
  parameter int STAT_W     = 5,
  parameter int TICK_DIV   = 10_000_000,
  parameter int INIT_VAL   = 16,
  parameter int LOW_THRESH = 4,
  parameter int ENERGY_IDX = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [7:0]                  rand_in,
  pet_stats_engine_if.slave           cmd,
  output logic [NUM_STATS*STAT_W-1:0] stats_flat,
  output logic                        tick,
  output logic [1:0]                  state,
  output logic [NUM_STATS-1:0]        low_alarm
);

  localparam int                CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_INI = STAT_W'(INIT_VAL);
  localparam logic [STAT_W:0]   LOW_T    = (STAT_W + 1)'(LOW_THRESH);

  typedef enum logic [1:0] {
    ST_AWAKE = 2'b00,
    ST_SLEEP = 2'b01,
    ST_DEAD  = 2'b10
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              tick_ev;
  logic              tick_q;
  logic              cmd_err_q;
  logic              cmd_acc;
  logic              id_ok;
  logic              all_zero;
  logic [STAT_W-1:0] stat_q [NUM_STATS];
  logic [STAT_W-1:0] stat_d [NUM_STATS];
  logic [STAT_W-1:0] upd_val;
  logic [STAT_W:0]   upd_sum;

  assign tick_ev = (cnt_q == CNT_LAST);
  assign cmd_acc = cmd.cmd_valid && cmd.cmd_ready;
  assign id_ok   = (int'(cmd.cmd_id) < NUM_STATS);

  // The prescaler free-runs in every state so tick timing never depends on the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (tick_ev) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Per-stat update: decay (or sleep recovery) first, then the saturating add.
  always_comb begin
    upd_val = '0;
    upd_sum = '0;
    for (int i = 0; i < NUM_STATS; i++) begin
      upd_val = stat_q[i];
      if (tick_ev && state_q == ST_AWAKE && rand_in[3'(i % 8)] && upd_val != '0) begin
        upd_val = upd_val - 1'b1;
      end
      if (tick_ev && state_q == ST_SLEEP && i == ENERGY_IDX && upd_val != STAT_MAX) begin
        upd_val = upd_val + 1'b1;
      end
      if (cmd_acc && cmd.cmd_id == 3'(i)) begin
        upd_sum = {1'b0, upd_val} + {1'b0, cmd.cmd_amount};
        upd_val = upd_sum[STAT_W] ? STAT_MAX : upd_sum[STAT_W-1:0];
      end
      stat_d[i] = upd_val;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STATS; i++) begin
        stat_q[i] <= STAT_INI;
      end
      tick_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_STATS; i++) begin
        stat_q[i] <= stat_d[i];
      end
      tick_q    <= tick_ev;
      cmd_err_q <= cmd_acc && !id_ok;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_AWAKE;
    end else begin
      state_q <= state_d;
    end
  end

  // Transitions look at the post-update stats so a fatal decay is caught the same edge.
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NUM_STATS; i++) begin
      if (stat_d[i] != '0) begin
        all_zero = 1'b0;
      end
    end
    state_d = state_q;
    case (state_q)
      ST_AWAKE: begin
        if (all_zero) begin
          state_d = ST_DEAD;
        end else if (stat_d[ENERGY_IDX] == '0) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (stat_d[ENERGY_IDX] == STAT_MAX) begin
          state_d = ST_AWAKE;
        end
      end
      ST_DEAD: begin
        state_d = ST_DEAD;
      end
      default: begin
        state_d = ST_AWAKE;
      end
    endcase
  end

  always_comb begin
    cmd.cmd_ready = (state_q == ST_AWAKE);
    cmd.cmd_err   = cmd_err_q;
    state         = state_q;
    tick          = tick_q;
  end

  always_comb begin
    stats_flat = '0;
    low_alarm  = '0;
    for (int i = 0; i < NUM_STATS; i++) begin
      stats_flat[i*STAT_W +: STAT_W] = stat_q[i];
      low_alarm[i]                   = ({1'b0, stat_q[i]} < LOW_T);
    end
  end

endmodule
